// File: rtl/apb_mem_slave_if.sv
// APB bus bundle for apb_mem_slave.
// The PSTRB lane strobes exist only when APB_PSTRB_EN is defined.
interface apb_mem_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
`ifdef APB_PSTRB_EN
    logic [DATA_W/8-1:0] PSTRB;
`endif
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

`ifdef APB_PSTRB_EN
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                    output PRDATA, PREADY, PSLVERR);
`else
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
`endif
endinterface

// File: rtl/apb_mem_slave.sv
// Parametrised APB3 memory slave with wait states, PSLVERR on out-of-range or
// misaligned addresses, and saturating transfer statistics.
// Optional feature macro: APB_PSTRB_EN (byte-lane write strobes).
module apb_mem_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_mem_slave_if.slave   bus,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]       WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [IDX_W-1:0]  widx;
    logic              misalign;
    logic              err;
    logic              active;
    logic              ready;
    logic [NB-1:0]     strb;

    // Word index and range check; the extra bit keeps DEPTH == 2^ADDR_W representable.
    assign idx  = bus.PADDR >> LSB;
    assign widx = idx[IDX_W-1:0];

    generate
        if (LSB > 0) begin : g_lanes
            assign misalign = |bus.PADDR[LSB-1:0];
        end else begin : g_no_lanes
            assign misalign = 1'b0;
        end
    endgenerate

    assign err = ({1'b0, idx} >= (ADDR_W+1)'(DEPTH)) || misalign;

`ifdef APB_PSTRB_EN
    assign strb = bus.PSTRB;
`else
    assign strb = '1;
`endif

    // Ready is combinational from the registered wait counter so that zero
    // wait states complete in the first access cycle; held low during reset.
    assign active      = bus.PSEL & bus.PENABLE;
    assign ready       = active && (wait_cnt == WAIT_LAST) && !PRESET;
    assign bus.PREADY  = ready;
    assign bus.PSLVERR = ready & err;
    assign bus.PRDATA  = (ready && !bus.PWRITE && !err) ? mem[widx] : '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Access-phase state machine: count wait states, clear on completion or abort.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else if (!active || ready) begin
            // Completion, idle, or a master that dropped PSEL/PENABLE early.
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= ACCESS;
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Memory: reset to an index pattern, byte-lane write on an error-free completion.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else if (ready && bus.PWRITE && !err) begin
            for (int k = 0; k < NB; k++) begin
                if (strb[k]) begin
                    mem[widx][k*8 +: 8] <= bus.PWDATA[k*8 +: 8];
                end
            end
        end
    end

    // Statistics: exactly one saturating counter bumps per completed transfer.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else if (ready) begin
            if (err) begin
                err_count <= sat_inc(err_count);
            end else if (bus.PWRITE) begin
                wr_count <= sat_inc(wr_count);
            end else begin
                rd_count <= sat_inc(rd_count);
            end
        end
    end
endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB3-style memory-mapped slave, the successor to the fixed 8-bit register-file slave. It adds generic data, address and depth widths, and a configurable number of wait states counted in a proper access-phase state machine. It also adds PSLVERR for out-of-range or misaligned addresses and saturating transfer statistics counters. It sits behind the APB master on the same PCLK domain.

Parameters:
- ADDR_W, 8, PADDR width in bits (byte address).
- DATA_W, 32, data width in bits; one of 8, 16 or 32.
- DEPTH, 32, number of DATA_W-bit words; must be ≤ 2^(ADDR_W - log2(DATA_W/8)).
- WAIT_CYCLES, 0, access-phase wait states before PREADY is asserted; range 0..15.
- CNT_W, 16, width of each statistics counter.

Ports:
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte lane strobes; present only with APB_PSTRB_EN.
- PRDATA  out  DATA_W  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.
- wr_count  out  CNT_W  completed error-free writes.
- rd_count  out  CNT_W  completed error-free reads.
- err_count  out  CNT_W  completed transfers with PSLVERR=1.

Behaviour:

Reset (PRESET=1, asynchronous):
- mem[i] = i[DATA_W-1:0] for all i.
- Wait counter = 0; state = IDLE.
- All counters = 0.
- PREADY = 0, PSLVERR = 0, PRDATA = 0.
- A reset mid-transfer aborts the transfer with no memory update.

Decode:
- Lane bits: LSB = log2(DATA_W/8).
- idx = PADDR >> LSB.
- err = (idx ≥ DEPTH) or (PADDR[LSB-1:0] ≠ 0). When DATA_W = 8 there are no lane bits and misalignment cannot occur.

State machine:
- IDLE → ACCESS when PSEL & PENABLE (setup phase takes no action).
- ACCESS: wait counter increments each cycle while PSEL & PENABLE and counter < WAIT_CYCLES.
- PREADY = PSEL & PENABLE & (counter == WAIT_CYCLES). The output is combinational from the registered counter, so WAIT_CYCLES=0 gives zero-wait transfers.
- Completion edge is PSEL & PENABLE & PREADY. On that edge the counter clears and the state returns to IDLE. Back-to-back transfers (setup phase immediately following) are supported.
- If PSEL or PENABLE drops before completion (protocol violation): counter clears, state returns to IDLE, no memory or counter side effects.

Write:
- On the completion edge with !err, mem[idx] ← PWDATA, masked by PSTRB when APB_PSTRB_EN is defined.
- With err, the write is suppressed.

Read data:
- PRDATA = mem[idx] while PREADY & !PWRITE & !err; 0 otherwise.
- A read and a write to the same word cannot coincide (single port).

PSLVERR:
- PSLVERR = PREADY & err.

Counters:
- On each completion edge, exactly one of wr_count, rd_count or err_count increments.
- Each counter saturates at 2^CNT_W - 1 and does not wrap.

Optional Feature:
APB_PSTRB_EN
- Defined: PSTRB port exists. Byte lane k of mem[idx] is written only when PSTRB[k]=1. A write with PSTRB=0 completes normally, counts in wr_count, and leaves memory unchanged. Strobes are ignored on reads.
- Undefined: no PSTRB port; every write updates all DATA_W bits.

Test Plan:
- Reset, then read with defaults (WAIT_CYCLES=0), PADDR=0x08 → PREADY in the first access cycle, PRDATA=0x00000002, PSLVERR=0, rd_count=1.
- Write PADDR=0x0C, PWDATA=0xDEADBEEF, then read 0x0C → PRDATA=0xDEADBEEF; wr_count=1, rd_count=1.
- WAIT_CYCLES=3, write to 0x04 → PREADY low for 3 access cycles and high on the 4th; memory updates only on the completion edge.
- Read PADDR=0x80 (idx 32 ≥ DEPTH) and write PADDR=0x05 (misaligned) → PSLVERR=1 with PREADY, PRDATA=0, memory unchanged, err_count=2.
- APB_PSTRB_EN defined: write 0x11223344 to 0x10 with PSTRB=4'b0101 → word 4 reads 0x00220044 (old value 0x00000004 in lanes 1 and 3).
- Assert PRESET during a WAIT_CYCLES=3 access; also force err_count near saturation (CNT_W=4, 20 errors) → transfer aborted, all outputs 0; err_count holds at 15.
